// File: rtl/spi_fword_master.sv
// spi_fword_master: sends a 32-bit tuning word MSB-first as one mode-0 SPI frame; start is honoured only in IDLE.
// Define SPI_FWORD_CHECKSUM_EN to append an XOR checksum byte (5-byte frame).
module spi_fword_master #(
   parameter int CLK_DIV    = 4,
   parameter int GAP_CYCLES = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] fword,
   output logic        busy,
   output logic        done,
   output logic [31:0] rx_word,
   output logic        cs,
   output logic        sck,
   output logic        MOSI,
   input  logic        MISO
);

`ifdef SPI_FWORD_CHECKSUM_EN
   localparam int NBYTES = 5;
`else
   localparam int NBYTES = 4;
`endif
   localparam logic [7:0] DIV_M1    = 8'(CLK_DIV - 1);
   localparam logic [7:0] GAP_M1    = 8'(GAP_CYCLES - 1);
   localparam logic [2:0] LAST_BYTE = 3'(NBYTES - 1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, HOLD} state_t;

   state_t      state, state_nxt;
   logic [7:0]  cnt;
   logic [2:0]  bit_cnt;
   logic [2:0]  byte_cnt;
   logic        sck_r;
   logic [7:0]  tx_sh;
   logic [31:0] tx_word;
   logic [31:0] rx_sh;
   logic [31:0] rx_word_r;
   logic        done_r;
   logic        half_end;
   logic        byte_end;

   function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [2:0] idx);
      logic [7:0] b;
      b = 8'h00;
      case (idx)
         3'd0: b = w[31:24];
         3'd1: b = w[23:16];
         3'd2: b = w[15:8];
         3'd3: b = w[7:0];
`ifdef SPI_FWORD_CHECKSUM_EN
         3'd4: b = w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
`endif
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   assign half_end = (cnt == DIV_M1);
   // A byte ends on the falling sck edge that closes the high half of bit 7.
   assign byte_end = (state == SHIFT) && half_end && sck_r && (bit_cnt == 3'd7);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start) state_nxt = SETUP;
         SETUP: if (half_end) state_nxt = SHIFT;
         SHIFT: begin
            if (byte_end) begin
               if (byte_cnt == LAST_BYTE)  state_nxt = HOLD;
               else if (GAP_CYCLES == 0)   state_nxt = SHIFT;
               else                        state_nxt = GAP;
            end
         end
         GAP:   if (cnt == GAP_M1) state_nxt = SHIFT;
         HOLD:  if (half_end) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= 8'h00;
         bit_cnt   <= 3'd0;
         byte_cnt  <= 3'd0;
         sck_r     <= 1'b0;
         tx_sh     <= 8'h00;
         tx_word   <= 32'h0;
         rx_sh     <= 32'h0;
         rx_word_r <= 32'h0;
         done_r    <= 1'b0;
      end else begin
         // Counter restarts on every state change and on each SCK half-period.
         if ((state_nxt != state) || ((state == SHIFT) && half_end)) cnt <= 8'h00;
         else if (state != IDLE)                                     cnt <= cnt + 8'd1;

         done_r <= (state == HOLD) && half_end;

         case (state)
            IDLE: begin
               if (start) begin
                  tx_word  <= fword;
                  tx_sh    <= fword[31:24];
                  bit_cnt  <= 3'd0;
                  byte_cnt <= 3'd0;
               end
            end
            SHIFT: begin
               if (half_end) begin
                  sck_r <= ~sck_r;
                  if (!sck_r) begin
`ifdef SPI_FWORD_CHECKSUM_EN
                     if (byte_cnt != 3'd4) rx_sh <= {rx_sh[30:0], MISO};
`else
                     rx_sh <= {rx_sh[30:0], MISO};
`endif
                  end else if (bit_cnt == 3'd7) begin
                     bit_cnt  <= 3'd0;
                     byte_cnt <= byte_cnt + 3'd1;
                     tx_sh    <= pick_byte(tx_word, byte_cnt + 3'd1);
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     tx_sh   <= {tx_sh[6:0], 1'b0};
                  end
               end
            end
            HOLD: if (half_end) rx_word_r <= rx_sh;
            default: ;
         endcase
      end
   end

   assign busy    = (state != IDLE);
   assign cs      = (state == IDLE);
   assign sck     = sck_r;
   assign done    = done_r;
   assign rx_word = rx_word_r;
   assign MOSI    = ((state == SETUP) || (state == SHIFT) || (state == GAP)) ? tx_sh[7] : 1'b0;

endmodule

// File: tb/tb_spi_fword_master.sv
// Bench for spi_fword_master: instance 0 runs CLK_DIV=4/GAP=8, instance 1 runs CLK_DIV=1/GAP=0.
module tb_spi_fword_master;
`ifdef SPI_FWORD_CHECKSUM_EN
   localparam int NB = 5;
`else
   localparam int NB = 4;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  start, busy, done, cs, sck, mosi, miso;
   logic [31:0] fword   [2];
   logic [31:0] rx_word [2];
   logic [31:0] resp;
   logic [7:0]  exp_q[$];
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : u
      localparam int CD = (g == 0) ? 4 : 1;
      localparam int GP = (g == 0) ? 8 : 0;
      logic       prev_sck = 1'b0;
      logic [5:0] fcnt = '0;
      logic [2:0] nb = '0;
      logic [7:0] sh = '0;
      int         cs_run = 0, cs_len = 0, done_cnt = 0, rise_at = 0, sck_per = 0;
      logic [7:0] obs_q[$];

      // Slave: shifts resp out MSB-first, advancing on falling sck; ones after 32 bits.
      assign miso[g] = (fcnt < 6'd32) ? resp[5'd31 - fcnt[4:0]] : 1'b1;

      spi_fword_master #(.CLK_DIV(CD), .GAP_CYCLES(GP)) dut (
         .clk(clk), .rst(rst), .start(start[g]), .fword(fword[g]),
         .busy(busy[g]), .done(done[g]), .rx_word(rx_word[g]),
         .cs(cs[g]), .sck(sck[g]), .MOSI(mosi[g]), .MISO(miso[g]));

      always @(negedge clk) begin
         if (cs[g] !== 1'b0) begin
            if (cs_run != 0) cs_len = cs_run;
            cs_run = 0;
            fcnt   = '0;
            nb     = '0;
         end else begin
            cs_run++;
            if (prev_sck && !sck[g]) fcnt = fcnt + 6'd1;
            if (!prev_sck && sck[g]) begin
               sck_per = cs_run - rise_at;
               rise_at = cs_run;
               sh = {sh[6:0], mosi[g]};
               nb = nb + 3'd1;
               if (nb == 3'd0) obs_q.push_back(sh);
            end
         end
         if (done[g] === 1'b1) done_cnt++;
         prev_sck = sck[g];
      end
   end

   // which: 0 cs_len, 1 done_cnt, 2 sck_per, 3 observed byte count
   function automatic int stat(input int g, input int which);
      if (g == 0) begin
         case (which)
            0: return u[0].cs_len;
            1: return u[0].done_cnt;
            2: return u[0].sck_per;
            default: return u[0].obs_q.size();
         endcase
      end
      case (which)
         0: return u[1].cs_len;
         1: return u[1].done_cnt;
         2: return u[1].sck_per;
         default: return u[1].obs_q.size();
      endcase
   endfunction

   function automatic logic [7:0] obs_pop(input int g);
      if (g == 0) return u[0].obs_q.pop_front();
      return u[1].obs_q.pop_front();
   endfunction

   task automatic obs_flush(input int g);
      if (g == 0) u[0].obs_q.delete();
      else        u[1].obs_q.delete();
   endtask

   function automatic int cs_exp(input int g);
      int cd, gp;
      cd = (g == 0) ? 4 : 1;
      gp = (g == 0) ? 8 : 0;
      return 2 * cd + NB * 16 * cd + (NB - 1) * gp;
   endfunction

   // Called at a negedge; start is sampled on the following posedge.
   task automatic start_frame(input int g, input logic [31:0] fw, input bit push);
      fword[g] = fw;
      start[g] = 1'b1;
      @(negedge clk);
      start[g] = 1'b0;
      if (push) begin
         exp_q.push_back(fw[31:24]);
         exp_q.push_back(fw[23:16]);
         exp_q.push_back(fw[15:8]);
         exp_q.push_back(fw[7:0]);
         if (NB == 5) exp_q.push_back(fw[31:24] ^ fw[23:16] ^ fw[15:8] ^ fw[7:0]);
      end
   endtask

   task automatic wait_done(input int g);
      for (int i = 0; i < 5000; i++) begin
         if (done[g] === 1'b1) return;
         @(negedge clk);
      end
      tests++;
      fails++;
      $display("FAIL done_timeout inst=%0d: no done within 5000 cycles", g);
   endtask

   task automatic check_bytes(input int g, input string name);
      logic [7:0] e, o;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         tests++;
         if (stat(g, 3) == 0) begin
            fails++;
            $display("FAIL %s_mosi_missing: no byte seen, expected %02h", name, e);
         end else begin
            o = obs_pop(g);
            if (o !== e) begin
               fails++;
               $display("FAIL %s_mosi_byte: got %02h expected %02h", name, o, e);
            end
         end
      end
      tests++;
      if (stat(g, 3) != 0) begin
         fails++;
         $display("FAIL %s_mosi_extra: %0d unexpected bytes", name, stat(g, 3));
         obs_flush(g);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = '0;
      fword[0] = 32'h0;
      fword[1] = 32'h0;
      resp = 32'h0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         tests += 6;
         if (cs[g] !== 1'b1)       begin fails++; $display("FAIL reset_cs inst=%0d: got %b expected 1", g, cs[g]); end
         if (sck[g] !== 1'b0)      begin fails++; $display("FAIL reset_sck inst=%0d: got %b expected 0", g, sck[g]); end
         if (mosi[g] !== 1'b0)     begin fails++; $display("FAIL reset_mosi inst=%0d: got %b expected 0", g, mosi[g]); end
         if (busy[g] !== 1'b0)     begin fails++; $display("FAIL reset_busy inst=%0d: got %b expected 0", g, busy[g]); end
         if (done[g] !== 1'b0)     begin fails++; $display("FAIL reset_done inst=%0d: got %b expected 0", g, done[g]); end
         if (rx_word[g] !== 32'h0) begin fails++; $display("FAIL reset_rx inst=%0d: got %h expected 0", g, rx_word[g]); end
      end
   endtask

   task automatic test_frame();
      int d0;
      resp = 32'h11223344;
      d0 = stat(0, 1);
      start_frame(0, 32'hC5B09928, 1);
      tests += 2;
      if (busy[0] !== 1'b1) begin fails++; $display("FAIL frame_busy_on: got %b expected 1", busy[0]); end
      if (cs[0] !== 1'b0)   begin fails++; $display("FAIL frame_cs_low: got %b expected 0", cs[0]); end
      wait_done(0);
      tests += 2;
      if (busy[0] !== 1'b0) begin fails++; $display("FAIL frame_busy_at_done: got %b expected 0", busy[0]); end
      if (cs[0] !== 1'b1)   begin fails++; $display("FAIL frame_cs_at_done: got %b expected 1", cs[0]); end
      @(negedge clk);
      tests += 5;
      if (done[0] !== 1'b0)            begin fails++; $display("FAIL frame_done_pulse: got %b expected 0", done[0]); end
      if (stat(0, 0) != cs_exp(0))     begin fails++; $display("FAIL frame_cs_len: got %0d expected %0d", stat(0, 0), cs_exp(0)); end
      if (rx_word[0] !== 32'h11223344) begin fails++; $display("FAIL frame_rx_word: got %h expected 11223344", rx_word[0]); end
      if (stat(0, 1) - d0 != 1)        begin fails++; $display("FAIL frame_done_count: got %0d expected 1", stat(0, 1) - d0); end
      if (stat(0, 2) != 8)             begin fails++; $display("FAIL frame_sck_period: got %0d expected 8", stat(0, 2)); end
      check_bytes(0, "frame");
   endtask

   task automatic test_busy_ignore();
      int d0;
      resp = 32'h55AA0FF0;
      d0 = stat(0, 1);
      start_frame(0, 32'hC5B09928, 1);
      repeat (140) @(negedge clk);
      start_frame(0, 32'hC5B05B05, 0);
      wait_done(0);
      @(negedge clk);
      tests += 2;
      if (stat(0, 1) - d0 != 1)        begin fails++; $display("FAIL ignore_done_count: got %0d expected 1", stat(0, 1) - d0); end
      if (rx_word[0] !== 32'h55AA0FF0) begin fails++; $display("FAIL ignore_rx_word: got %h expected 55aa0ff0", rx_word[0]); end
      check_bytes(0, "ignore");
      repeat (20) @(negedge clk);
      tests += 2;
      if (busy[0] !== 1'b0)     begin fails++; $display("FAIL ignore_no_restart: busy got %b expected 0", busy[0]); end
      if (stat(0, 1) - d0 != 1) begin fails++; $display("FAIL ignore_done_late: got %0d expected 1", stat(0, 1) - d0); end
   endtask

   task automatic test_reset_mid();
      int d0;
      resp = 32'h0;
      start_frame(0, 32'hC5B05B05, 0);
      // 80 cycles into the frame: first high half of byte 2.
      repeat (80) @(negedge clk);
      tests++;
      if (sck[0] !== 1'b1) begin fails++; $display("FAIL rstmid_sck_pre: got %b expected 1", sck[0]); end
      d0 = stat(0, 1);
      rst = 1'b1;
      #1;
      tests += 4;
      if (cs[0] !== 1'b1)   begin fails++; $display("FAIL rstmid_cs: got %b expected 1", cs[0]); end
      if (sck[0] !== 1'b0)  begin fails++; $display("FAIL rstmid_sck: got %b expected 0", sck[0]); end
      if (busy[0] !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b expected 0", busy[0]); end
      if (mosi[0] !== 1'b0) begin fails++; $display("FAIL rstmid_mosi: got %b expected 0", mosi[0]); end
      repeat (3) @(negedge clk);
      obs_flush(0);
      rst = 1'b0;
      @(negedge clk);
      tests += 2;
      if (stat(0, 1) != d0)     begin fails++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", stat(0, 1) - d0); end
      if (rx_word[0] !== 32'h0) begin fails++; $display("FAIL rstmid_rx_clear: got %h expected 0", rx_word[0]); end
      resp = 32'hA1B2C3D4;
      start_frame(0, 32'hC5B05B05, 1);
      wait_done(0);
      @(negedge clk);
      tests += 3;
      if (rx_word[0] !== 32'hA1B2C3D4) begin fails++; $display("FAIL rstmid_rx_word: got %h expected a1b2c3d4", rx_word[0]); end
      if (stat(0, 0) != cs_exp(0))     begin fails++; $display("FAIL rstmid_cs_len: got %0d expected %0d", stat(0, 0), cs_exp(0)); end
      if (stat(0, 1) - d0 != 1)        begin fails++; $display("FAIL rstmid_done_count: got %0d expected 1", stat(0, 1) - d0); end
      check_bytes(0, "rstmid");
   endtask

   task automatic test_back_to_back();
      int d0;
      resp = 32'hDEADBEEF;
      d0 = stat(1, 1);
      start_frame(1, 32'hC5B09928, 1);
      wait_done(1);
      @(negedge clk);
      tests += 3;
      if (stat(1, 0) != cs_exp(1))     begin fails++; $display("FAIL b2b_cs_len1: got %0d expected %0d", stat(1, 0), cs_exp(1)); end
      if (rx_word[1] !== 32'hDEADBEEF) begin fails++; $display("FAIL b2b_rx_word1: got %h expected deadbeef", rx_word[1]); end
      if (stat(1, 2) != 2)             begin fails++; $display("FAIL b2b_sck_period: got %0d expected 2", stat(1, 2)); end
      resp = 32'h13579BDF;
      start_frame(1, 32'h0F1E2D3C, 1);
      tests++;
      if (busy[1] !== 1'b1) begin fails++; $display("FAIL b2b_accept: busy got %b expected 1", busy[1]); end
      wait_done(1);
      @(negedge clk);
      tests += 3;
      if (stat(1, 0) != cs_exp(1))     begin fails++; $display("FAIL b2b_cs_len2: got %0d expected %0d", stat(1, 0), cs_exp(1)); end
      if (rx_word[1] !== 32'h13579BDF) begin fails++; $display("FAIL b2b_rx_word2: got %h expected 13579bdf", rx_word[1]); end
      if (stat(1, 1) - d0 != 2)        begin fails++; $display("FAIL b2b_done_count: got %0d expected 2", stat(1, 1) - d0); end
      check_bytes(1, "b2b");
      tests++;
      if (mosi[1] !== 1'b0) begin fails++; $display("FAIL b2b_idle_mosi: got %b expected 0", mosi[1]); end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_busy_ignore();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
